stream_mux_n: RTL and testbench
===============================

STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width per channel in bits.
REQ-002 The block SHALL have parameter N, default 3, legal 2..16, giving the input channel count.
REQ-003 The block SHALL have parameter SELW, default $clog2(N), giving the select and source-index width.
REQ-004 The block SHALL have the port clk  input  1  clock; all state changes on its rising edge.
REQ-005 The block SHALL have the port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have the port in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have the port in_valid  input  N  per-channel valid.
REQ-008 The block SHALL have the port in_ready  output  N  per-channel ready.
REQ-009 The block SHALL have the port mode  input  1  selection mode: 0 = explicit select, 1 = round-robin.
REQ-010 The block SHALL have the port sel  input  SELW  channel index, used only when mode=0.
REQ-011 The block SHALL have the port out_data  output  WIDTH  registered output data.
REQ-012 The block SHALL have the port out_src  output  SELW  index of the channel that supplied out_data.
REQ-013 The block SHALL have the port out_valid  output  1  output register holds data.
REQ-014 The block SHALL have the port out_ready  input  1  downstream accepts.
REQ-015 The block SHALL have the port err_sel  output  1  combinational flag: mode=0 and sel>=N.
REQ-016 The block SHALL have the port xfer_cnt  output  16  input-transfer count (see Configuration).

Function
REQ-017 A single-entry output register SHALL set load_en = !out_valid || out_ready.
REQ-018 In mode=0, the grant SHALL be channel sel when sel<N and in_valid[sel]=1; otherwise there is no grant.
REQ-019 In mode=1, the grant SHALL be the first channel with in_valid=1, searching from (last_ptr+1) mod N upward with wrap to 0.
REQ-020 last_ptr SHALL update to the granted index only on an accepted transfer.
REQ-021 in_ready[i] SHALL be 1 only when channel i is granted and load_en=1; at most one in_ready bit is high per cycle.
REQ-022 An input transfer SHALL occur on channel i when in_valid[i] && in_ready[i].
REQ-023 On an input transfer, the next edge SHALL load out_data, set out_src=i, and set out_valid=1 (latency 1 cycle).
REQ-024 When out_valid && out_ready and there is no input transfer, out_valid SHALL clear on the next edge.
REQ-025 Draining the output and accepting an input in the same cycle SHALL give full throughput: out_valid stays 1 with the new data.
REQ-026 When out_valid=1 and out_ready=0, out_data and out_src SHALL hold stable and all in_ready bits SHALL be 0.
REQ-027 In mode=0 with sel>=N, err_sel SHALL be 1, no channel is granted, and the output register SHALL be unaffected apart from draining.
REQ-028 A change of mode or sel SHALL affect only the next grant; held output data SHALL be unaffected.
REQ-029 in_data of non-granted channels SHALL have no effect on any output.

Reset
REQ-030 While rst_n=0, the block SHALL force out_valid=0, out_data=0, out_src=0, last_ptr=N-1 (so channel 0 has first round-robin priority), and xfer_cnt=0.
REQ-031 Reset asserted mid-transfer SHALL discard held data; the first grant after release SHALL follow REQ-018/REQ-019 from the reset state.
REQ-032 in_ready SHALL be 0 while rst_n=0.

Configuration
REQ-033 With macro STREAM_MUX_N_XFER_CNT_EN defined, xfer_cnt SHALL increment by 1 on every input transfer and saturate at 16'hFFFF.
REQ-034 Without STREAM_MUX_N_XFER_CNT_EN, xfer_cnt SHALL be constant 0 and no counter logic is generated; all other behaviour SHALL be identical.

Verification
REQ-035 Bench SHALL cover explicit select: mode=0, sel=2, in_valid=3'b111, ch2 data=32'hC0DE0002, out_ready=1 -> next cycle out_valid=1, out_data=32'hC0DE0002, out_src=2.
REQ-036 Bench SHALL cover invalid select: mode=0, sel=3, in_valid=3'b111 -> err_sel=1, in_ready=3'b000, out_valid falls to 0 after drain.
REQ-037 Bench SHALL cover round-robin: mode=1, in_valid=3'b111 held, out_ready=1 -> out_src sequence 0,1,2,0, one per cycle.
REQ-038 Bench SHALL cover backpressure: out_ready=0 with out_valid=1 for 5 cycles -> out_data stable, in_ready=0; release -> next transfer lands 1 cycle later.
REQ-039 Bench SHALL cover mid-operation reset: rst_n pulsed low with out_valid=1 -> out_valid=0 and out_data=0 immediately; after release with mode=1 and in_valid=3'b110 -> first out_src=1.
REQ-040 Bench SHALL cover the counter with STREAM_MUX_N_XFER_CNT_EN: 10 transfers -> xfer_cnt=10; preload to 16'hFFFE plus 3 transfers -> 16'hFFFF; without the macro -> 0.

Source files
------------

// File: rtl/stream_mux_n.sv
// stream_mux_n: N-input stream multiplexer feeding a single-entry output register.
// Mode 0 picks the channel given by sel; mode 1 arbitrates round-robin among valid channels.
// Optional macro STREAM_MUX_N_XFER_CNT_EN adds a saturating 16-bit input-transfer counter;
// without it xfer_cnt is tied to zero.
module stream_mux_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 3,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_sel,
    output logic [15:0]          xfer_cnt
);

    localparam int unsigned CNT_W = 16;

    logic [SELW-1:0]  last_ptr;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load_en;
    logic             xfer;

    // Output register can take new data when empty or being drained this cycle.
    assign load_en = !out_valid || out_ready;
    assign xfer    = rst_n && gnt_vld && load_en;
    assign err_sel = !mode && (32'(sel) >= N);

    // Grant selection: explicit index, or nearest valid channel after last_ptr.
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        best_d  = N;
        d       = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (SELW'(i) == sel) begin
                    gnt_vld = in_valid[i];
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                // Distance from (last_ptr+1) mod N going upward with wrap.
                d = (i + N - 1 - 32'(last_ptr)) % N;
                if (in_valid[i] && (d < best_d)) begin
                    best_d  = d;
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end
    end

    // Data steering and one-hot ready for the granted channel only.
    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = xfer;
            end
        end
    end

    // Output register, source tag and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            last_ptr  <= SELW'(N - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_src   <= gnt_idx;
            last_ptr  <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_N_XFER_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of accepted input transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: directed stimulus with a behavioural reference model and per-cycle compare.
`timescale 1ns/1ps
module tb_stream_mux_n;

    localparam int W = 32;
    localparam int N = 3;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_src;
    logic            out_valid;
    logic            out_ready;
    logic            err_sel;
    logic [15:0]     xfer_cnt;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 0;

    // Reference model state
    bit        m_valid;
    logic [W-1:0] m_data;
    int        m_src;
    int        m_ptr;
    int        m_cnt;

    stream_mux_n #(.WIDTH(W), .N(N), .SELW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
        .err_sel(err_sel), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the rules grant right now (from the model's pointer).
    function automatic void model_grant(output bit gv, output int gi);
        gv = 0;
        gi = 0;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel] == 1'b1) begin
                gv = 1;
                gi = int'(sel);
            end
        end else begin
            for (int s = 1; s <= N; s++) begin
                int c;
                c = (m_ptr + s) % N;
                if (in_valid[c] == 1'b1) begin
                    gv = 1;
                    gi = c;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] model_ready();
        bit gv;
        int gi;
        model_grant(gv, gi);
        if (rst_n && gv && (!m_valid || out_ready)) return N'(1) << gi;
        return '0;
    endfunction

    // Model advance on each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = N - 1;
            m_cnt   = 0;
        end else begin
            bit gv;
            int gi;
            model_grant(gv, gi);
            if (gv && (!m_valid || out_ready)) begin
                m_valid = 1;
                m_data  = in_data[gi*W +: W];
                m_src   = gi;
                m_ptr   = gi;
`ifdef STREAM_MUX_N_XFER_CNT_EN
                m_cnt   = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
`endif
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_in_ready", 64'(in_ready), 64'(model_ready()));
            chk("cyc_err_sel", 64'(err_sel), 64'(!mode && int'(sel) >= N));
            chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("cyc_out_data", 64'(out_data), 64'(m_data));
                chk("cyc_out_src", 64'(out_src), 64'(m_src));
            end
            chk("cyc_xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] chd(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    initial begin
        logic [2:0] rr_exp [4];
        rr_exp[0] = 3'd0; rr_exp[1] = 3'd1; rr_exp[2] = 3'd2; rr_exp[3] = 3'd0;

        rst_n = 1'b0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = chd(i);
        in_valid  = 3'b111;
        mode      = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b1;
        #2;
        cmp_on = 1;
        cyc();
        cyc();
        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
        in_valid = 3'b000;
        rst_n = 1'b1;
        cyc();

        // Explicit select of channel 2
        sel = 2'd2;
        in_valid = 3'b111;
        #1;
        chk("sel2_in_ready", 64'(in_ready), 64'(3'b100));
        chk("sel2_err_sel", 64'(err_sel), 64'(0));
        cyc();
        chk("sel2_out_valid", 64'(out_valid), 64'(1));
        chk("sel2_out_data", 64'(out_data), 64'(32'hC0DE0002));
        chk("sel2_out_src", 64'(out_src), 64'(2));

        // Out-of-range select: no grant, output drains
        sel = 2'd3;
        #1;
        chk("bad_err_sel", 64'(err_sel), 64'(1));
        chk("bad_in_ready", 64'(in_ready), 64'(3'b000));
        cyc();
        chk("bad_drained", 64'(out_valid), 64'(0));
        cyc();
        chk("bad_stays_empty", 64'(out_valid), 64'(0));

        // Round-robin from pointer at channel 2
        mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rr_out_src", 64'(out_src), 64'(rr_exp[k]));
            chk("rr_out_data", 64'(out_data), 64'(chd(int'(rr_exp[k]))));
        end

        // Backpressure; mode/sel and non-granted data change while held
        out_ready = 1'b0;
        mode = 1'b0;
        sel = 2'd1;
        in_data[2*W +: W] = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            cyc();
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_out_data", 64'(out_data), 64'(32'hC0DE0000));
            chk("bp_out_src", 64'(out_src), 64'(0));
        end
        in_data[2*W +: W] = chd(2);
        out_ready = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'(3'b010));
        cyc();
        chk("rel_out_src", 64'(out_src), 64'(1));
        chk("rel_out_data", 64'(out_data), 64'(32'hC0DE0001));

        // Mid-operation reset with data held
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_out_data", 64'(out_data), 64'(0));
        chk("mrst_in_ready", 64'(in_ready), 64'(0));
        mode = 1'b1;
        in_valid = 3'b110;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("mrst_first_ready", 64'(in_ready), 64'(3'b010));
        cyc();
        chk("mrst_first_src", 64'(out_src), 64'(1));
        chk("mrst_first_valid", 64'(out_valid), 64'(1));

        // Nine more transfers alternating 2,1,...
        for (int k = 0; k < 9; k++) cyc();
        chk("rr2_out_src", 64'(out_src), 64'(2));
`ifdef STREAM_MUX_N_XFER_CNT_EN
        chk("cnt_ten", 64'(xfer_cnt), 64'(10));
        while (m_cnt < 16'hFFFE) cyc();
        chk("cnt_fffe", 64'(xfer_cnt), 64'(16'hFFFE));
        for (int k = 0; k < 3; k++) cyc();
        chk("cnt_sat", 64'(xfer_cnt), 64'(16'hFFFF));
`else
        chk("cnt_off", 64'(xfer_cnt), 64'(0));
`endif

        // Drain to empty
        in_valid = 3'b000;
        cyc();
        chk("final_drain", 64'(out_valid), 64'(0));
        cyc();
        cmp_on = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
